// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP slice as an unsigned multiply-accumulate engine for dot products of 1..LEN_MAX terms.
// Latency: a result is valid 4 cycles after the last operand issue (N+4 after start when there are no bubbles).
// Backpressure: s_ready is high only in RUN; the result is held stable in DONE until res_ready.
module dsp_mac_sequencer #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_ceopmode,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // OPMODE words: X=M with Z=0 loads the first product, X=M with Z=P accumulates.
  localparam logic [7:0] OPM_LOAD = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC  = 8'b0000_1001;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             v1_q, v2_q, v3_q;
  logic [7:0]       opmode_q, opmode_d;
  logic             busy_q, s_ready_q, res_valid_q;
  logic [47:0]      res_data_q;
  logic             issue;
  logic             capture;

  // An issue is an accepted operand beat; it is the v0 stage of the term pipeline.
  assign issue = s_valid & s_ready_q;

  // A/B are presented combinationally so the slice's A1/B1 registers capture them in the issue cycle.
  always_comb begin
    dsp_a   = issue ? s_a : 18'd0;
    dsp_b   = issue ? s_b : 18'd0;
    dsp_cea = issue;
    dsp_ceb = issue;
  end

  // Next-state logic: job acceptance, term counting, drain detection and result handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d = RUN;
          cnt_d   = len;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (issue) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last term's P update is visible once only v3 remains in the pipeline.
        if (v3_q && !v2_q && !v1_q) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // OPMODE is registered so it is on the pins during the v1 cycle; it holds when no term is in flight.
  always_comb begin
    opmode_d = opmode_q;
    if (issue) opmode_d = first_q ? OPM_LOAD : OPM_ACC;
  end

  // State, counter, stage-valid pipeline and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      opmode_q    <= 8'd0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 48'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      v1_q        <= issue;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      opmode_q    <= opmode_d;
      busy_q      <= (state_d != IDLE);
      s_ready_q   <= (state_d == RUN);
      res_valid_q <= (state_d == DONE);
      if (capture) res_data_q <= dsp_p;
    end
  end

  assign busy         = busy_q;
  assign s_ready      = s_ready_q;
  assign dsp_opmode   = opmode_q;
  assign dsp_cem      = v1_q;
  assign dsp_ceopmode = v1_q;
  assign dsp_cep      = v2_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP slice (A1/B1, M, OPMODE and P registers).
// Expected dot products are computed from the driven operand pairs and queued; they are popped on the result handshake.
module tb_dsp_mac_sequencer;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             RST;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a, s_b;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  int checks = 0;
  int errors = 0;

  logic [47:0] exp_q[$];
  logic [17:0] qa[$];
  logic [17:0] qb[$];
  logic [7:0]  op_q[$];
  int          cep_cnt;

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .RST(RST), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
    .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Behavioural slice: A1REG/B1REG, MREG, OPMODEREG, PREG, unsigned operands.
  logic [17:0] sl_a, sl_b;
  logic [35:0] sl_m;
  logic [7:0]  sl_op;
  logic [47:0] sl_p;
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sl_a <= '0; sl_b <= '0; sl_m <= '0; sl_op <= '0; sl_p <= '0;
    end else begin
      if (dsp_cea) sl_a <= dsp_a;
      if (dsp_ceb) sl_b <= dsp_b;
      if (dsp_cem) sl_m <= 36'(sl_a) * 36'(sl_b);
      if (dsp_ceopmode) sl_op <= dsp_opmode;
      if (dsp_cep) begin
        if (sl_op == 8'b0000_1001)      sl_p <= sl_p + 48'(sl_m);
        else if (sl_op == 8'b0000_0001) sl_p <= 48'(sl_m);
        else                            sl_p <= 48'hBAD_BAD_BAD_BAD;
      end
    end
  end
  assign dsp_p = sl_p;

  // Runs one job from qa/qb; returns the cycle (start = cycle 0) at which res_valid was first seen.
  task automatic do_job(input int n, input bit bubbles, input int hold, input bit stray, output int lat);
    int          idx, cyc;
    bit          done;
    logic [47:0] sum, expv, held;
    sum = '0;
    for (int i = 0; i < n; i++) sum += 48'(qa[i]) * 48'(qb[i]);
    exp_q.push_back(sum);
    op_q.delete();
    cep_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(n);
    idx = 0; cyc = 0; lat = -1; done = 1'b0;
    while (!done && cyc < 3 * n + 40) begin
      @(posedge clk); #1;
      cyc++;
      start = stray && (cyc == 2);
      len   = LEN_W'(7);
      if (dsp_cem) op_q.push_back(dsp_opmode);
      if (dsp_cep) cep_cnt++;
      if (res_valid) begin
        lat = cyc; done = 1'b1; s_valid = 1'b0;
      end else if (idx < n && s_ready && (!bubbles || (cyc % 2 == 1))) begin
        s_valid = 1'b1; s_a = qa[idx]; s_b = qb[idx];
        #1;
        checks++;
        if (dsp_a !== qa[idx] || dsp_b !== qb[idx] || dsp_cea !== 1'b1 || dsp_ceb !== 1'b1) begin
          errors++;
          $display("FAIL issue[%0d] got a=%h b=%h ce=%b%b want a=%h b=%h ce=11",
                   idx, dsp_a, dsp_b, dsp_cea, dsp_ceb, qa[idx], qb[idx]);
        end
        idx++;
      end else if (idx >= n) begin
        // Stray beats after the last term must not be accepted.
        s_valid = 1'b1; s_a = 18'h3FFFF; s_b = 18'h3FFFF;
        #1;
        checks++;
        if (dsp_cea !== 1'b0 || dsp_a !== 18'd0) begin
          errors++;
          $display("FAIL stray_beat cyc %0d got cea=%b a=%h want cea=0 a=0", cyc, dsp_cea, dsp_a);
        end
      end else begin
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    expv = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL job_timeout n=%0d got no res_valid within %0d cycles want res_valid", n, cyc);
      return;
    end
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = (h == 0); len = LEN_W'(7);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_data !== held) begin
        errors++;
        $display("FAIL hold[%0d] got valid=%b data=%h want valid=1 data=%h", h, res_valid, res_data, held);
      end
    end
    if (res_data !== expv) begin
      errors++;
      $display("FAIL result n=%0d got %h want %h", n, res_data, expv);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got busy=%b valid=%b want busy=0 valid=0", busy, res_valid);
    end
  endtask

  task automatic test_reset();
    int k;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        qa = '{18'd9, 18'd10, 18'd11}; qb = '{18'd2, 18'd3, 18'd4};
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(3);
        k = $urandom_range(1, 3);
        for (int c = 1; c <= k; c++) begin
          @(posedge clk); #1;
          start = 1'b0;
          s_valid = 1'b1; s_a = qa[c-1]; s_b = qb[c-1];
        end
        #2; RST = 1'b1; #1;
      end
      checks++;
      if ({busy, s_ready, res_valid, res_data, dsp_a, dsp_b, dsp_opmode,
           dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep} !== '0) begin
        errors++;
        $display("FAIL reset_outputs ph%0d got busy=%b rdy=%b vld=%b data=%h a=%h b=%h op=%h ce=%b%b%b%b%b want all 0",
                 ph, busy, s_ready, res_valid, res_data, dsp_a, dsp_b, dsp_opmode,
                 dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep);
      end
      s_valid = 1'b0;
      @(posedge clk); #1;
      RST = 1'b0;
    end
    qa = '{18'd3, 18'd5}; qb = '{18'd4, 18'd6};
    do_job(2, 1'b0, 0, 1'b0, k);
  endtask

  task automatic test_single();
    int lat;
    qa = '{18'h3FFFF}; qb = '{18'h3FFFF};
    do_job(1, 1'b0, 0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL single_latency got %0d want 5", lat);
    end
  endtask

  task automatic test_back_to_back(input bit bubbles);
    int lat;
    logic [7:0] exp_op[4];
    exp_op = '{8'h01, 8'h09, 8'h09, 8'h09};
    qa = '{18'd1, 18'd3, 18'd5, 18'd7}; qb = '{18'd2, 18'd4, 18'd6, 18'd8};
    do_job(4, bubbles, 0, 1'b0, lat);
    checks++;
    if (cep_cnt !== 4) begin
      errors++;
      $display("FAIL cep_pulses bub=%0d got %0d want 4", bubbles, cep_cnt);
    end
    checks++;
    if (op_q.size() !== 4) begin
      errors++;
      $display("FAIL opmode_count bub=%0d got %0d want 4", bubbles, op_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (op_q[i] !== exp_op[i]) begin
          errors++;
          $display("FAIL opmode[%0d] bub=%0d got %h want %h", i, bubbles, op_q[i], exp_op[i]);
        end
      end
    end
    if (!bubbles) begin
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL b2b_latency got %0d want 8", lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    qa = '{18'd100, 18'd200, 18'd300}; qb = '{18'd7, 18'd11, 18'd13};
    do_job(3, 1'b0, 10, 1'b1, lat);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL after_stray_start got busy=%b rdy=%b want 0 0", busy, s_ready);
      end
    end
  endtask

  task automatic test_illegal_start();
    @(posedge clk); #1;
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL len0_start got busy=%b rdy=%b want 0 0", busy, s_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_len();
    int lat;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4095; i++) begin
      qa.push_back(18'h3FFFF); qb.push_back(18'h3FFFF);
    end
    do_job(4095, 1'b0, 0, 1'b0, lat);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0;
    s_a = '0; s_b = '0; res_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_backpressure();
    test_illegal_start();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
